// File: rtl/mem_port_arbiter.sv
// Single-port data-memory arbiter between the datapath core and a DMA/debug requester.
// Core is preferred; a bounded streak counter guarantees the DMA gets through.
module mem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int MAX_CONSEC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] LP_MAX = 4'(MAX_CONSEC);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_id;        // 1 = DMA owns the current transaction
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_consec;
  logic [DATA_W-1:0]   r_core_rdata;
  logic [DATA_W-1:0]   r_dma_rdata;

  logic                w_any_req;
  logic                w_dma_sel;
  logic                w_launch;

  assign w_any_req = core_req | dma_req;
  // DMA wins when alone, or when the core has used up its streak allowance.
  assign w_dma_sel = dma_req & (~core_req | (r_consec == LP_MAX));
  assign w_launch  = (r_state == ST_IDLE) & w_any_req;

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    core_gnt    = 1'b0;
    dma_gnt     = 1'b0;
    core_rvalid = 1'b0;
    dma_rvalid  = 1'b0;
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    busy        = 1'b1;
    core_rdata  = r_core_rdata;
    dma_rdata   = r_dma_rdata;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_any_req) begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_wr      = r_we;
        mem_rd      = ~r_we;
        core_gnt    = ~r_id;
        dma_gnt     = r_id;
        w_state_nxt = r_we ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        // Read data arrives this cycle; present it immediately and hold it afterwards.
        core_rvalid = ~r_id;
        dma_rvalid  = r_id;
        if (r_id) begin
          dma_rdata = mem_rdata;
        end else begin
          core_rdata = mem_rdata;
        end
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_id         <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_consec     <= 4'd0;
      r_core_rdata <= '0;
      r_dma_rdata  <= '0;
    end else begin
      if (w_launch) begin
        r_id    <= w_dma_sel;
        r_we    <= w_dma_sel ? dma_we    : core_we;
        r_addr  <= w_dma_sel ? dma_addr  : core_addr;
        r_wdata <= w_dma_sel ? dma_wdata : core_wdata;
        if (w_dma_sel) begin
          r_consec <= 4'd0;
        end else if (dma_req && (r_consec != LP_MAX)) begin
          r_consec <= r_consec + 4'd1;
        end
      end
      if (r_state == ST_RESP) begin
        if (r_id) begin
          r_dma_rdata <= mem_rdata;
        end else begin
          r_core_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers queue expected commands/read data,
// a negedge monitor pops and compares whenever a grant or rvalid appears.
module tb_mem_port_arbiter;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 9;
  localparam int MAX_CONSEC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              core_req, core_we, dma_req, dma_we;
  logic [ADDR_W-1:0] core_addr, dma_addr, mem_addr;
  logic [DATA_W-1:0] core_wdata, dma_wdata, core_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic              core_gnt, core_rvalid, dma_gnt, dma_rvalid, mem_wr, mem_rd, busy;

  mem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_CONSEC(MAX_CONSEC)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Synchronous RAM: read data valid the cycle after mem_rd.
  logic [DATA_W-1:0] ram [0:511];
  logic              ram_clr;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 512; i++) ram[i] <= '0;
    end else begin
      if (mem_wr) ram[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= ram[mem_addr];
    end
  end

  int   cyc = 0;
  logic dma_req_e = 1'b0;
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    dma_req_e <= dma_req;
  end

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  cmd_t              core_cmd_q[$], dma_cmd_q[$];
  logic [DATA_W-1:0] core_rd_q[$], dma_rd_q[$];
  logic [DATA_W-1:0] model [0:511];
  bit                grant_log[$];

  // Issue one transaction; expectations are queued at issue time. Returns at the grant cycle.
  task automatic xact(input bit is_dma, input bit we, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wd, output int lat);
    cmd_t c;
    bit   got;
    c.we = we; c.addr = addr; c.wdata = wd;
    if (is_dma) dma_cmd_q.push_back(c); else core_cmd_q.push_back(c);
    if (!we) begin
      if (is_dma) dma_rd_q.push_back(model[addr]); else core_rd_q.push_back(model[addr]);
    end else begin
      model[addr] = wd;
    end
    if (is_dma) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wd;
    end else begin
      core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wd;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      got = is_dma ? dma_gnt : core_gnt;
    end
    if (!got) check(is_dma ? "dma_gnt_timeout" : "core_gnt_timeout", 64'd0, 64'd1);
    if (is_dma) dma_req = 1'b0; else core_req = 1'b0;
  endtask

  task automatic rand_driver(input bit is_dma, input int n);
    int                lat;
    bit                we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    for (int i = 0; i < n; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = {is_dma, 4'd0, 4'($urandom_range(0, 15))};
      wd = $urandom;
      xact(is_dma, we, a, wd, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic mon_cmd(input bit is_dma);
    cmd_t c;
    if (is_dma ? (dma_cmd_q.size() == 0) : (core_cmd_q.size() == 0)) begin
      check(is_dma ? "dma_gnt_unexpected" : "core_gnt_unexpected", 64'd1, 64'd0);
      return;
    end
    if (is_dma) c = dma_cmd_q.pop_front(); else c = core_cmd_q.pop_front();
    check("cmd_mem_wr", mem_wr, c.we);
    check("cmd_mem_rd", mem_rd, !c.we);
    check("cmd_mem_addr", mem_addr, c.addr);
    if (c.we) check("cmd_mem_wdata", mem_wdata, c.wdata);
    grant_log.push_back(is_dma);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant or read data.
  initial begin : monitor
    int                streak;
    logic [DATA_W-1:0] last_c, last_d;
    streak = 0; last_c = '0; last_d = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        streak = 0; last_c = '0; last_d = '0;
      end
      if (mem_wr === 1'b1 || mem_rd === 1'b1) check("mem_wr_rd_exclusive", mem_wr & mem_rd, 1'b0);
      if (core_gnt === 1'b1 || dma_gnt === 1'b1) begin
        check("single_gnt", core_gnt & dma_gnt, 1'b0);
        mon_cmd(dma_gnt === 1'b1);
        if (core_gnt === 1'b1 && dma_req_e) begin
          streak++;
          check("dma_not_starved", streak <= MAX_CONSEC, 1'b1);
        end
        if (dma_gnt === 1'b1) streak = 0;
      end
      if (core_rvalid === 1'b1) begin
        check("single_rvalid", dma_rvalid, 1'b0);
        check("dma_rdata_hold", dma_rdata, last_d);
        if (core_rd_q.size() == 0) check("core_rvalid_unexpected", 64'd1, 64'd0);
        else check("core_rdata", core_rdata, core_rd_q.pop_front());
        last_c = core_rdata;
      end else if (dma_rvalid === 1'b1) begin
        check("core_rdata_hold", core_rdata, last_c);
        if (dma_rd_q.size() == 0) check("dma_rvalid_unexpected", 64'd1, 64'd0);
        else check("dma_rdata", dma_rdata, dma_rd_q.pop_front());
        last_d = dma_rdata;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat, lat_d, base, cnt, t_req;
    bit exp_who;
    reset = 1'b0; ram_clr = 1'b1;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    dma_req = 0;  dma_we = 0;  dma_addr = '0;  dma_wdata = '0;
    for (int i = 0; i < 512; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    ram_clr = 1'b0;

    // Reset state
    check("rst_strobes", {core_gnt, dma_gnt, core_rvalid, dma_rvalid, mem_wr, mem_rd, busy}, 7'd0);
    check("rst_rdata", {core_rdata, dma_rdata}, 64'd0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    reset = 1'b1;

    // Both requesters streaming writes straight out of reset: expect C,C,C,C,D repeating
    base = grant_log.size();
    fork
      begin
        for (int i = 0; i < 8; i++) xact(1'b0, 1'b1, 9'(i), 32'hC000_0000 + i, lat);
      end
      begin
        for (int i = 0; i < 2; i++) xact(1'b1, 1'b1, 9'h100 + 9'(i), 32'hD000_0000 + i, lat_d);
      end
    join
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (cnt == MAX_CONSEC) begin exp_who = 1'b1; cnt = 0; end
      else begin exp_who = 1'b0; cnt++; end
      if (base + k < grant_log.size()) check("grant_order", grant_log[base + k], exp_who);
      else check("grant_order_missing", 64'd0, 64'd1);
    end

    // Core write: granted the next cycle, back to IDLE one cycle later
    @(negedge clk);
    xact(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, lat);
    check("wr_latency", lat, 1);
    check("wr_mem_wr", mem_wr, 1'b1);
    check("wr_mem_addr", mem_addr, 9'h010);
    check("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    check("wr_idle_after", {busy, mem_wr, core_gnt}, 3'b000);

    // DMA read of 0x1FF: grant at +1, rvalid with data at +2, core untouched
    xact(1'b1, 1'b1, 9'h1FF, 32'h12345678, lat);
    @(negedge clk);
    xact(1'b1, 1'b0, 9'h1FF, '0, lat);
    check("rd_latency", lat, 1);
    check("rd_mem_rd", mem_rd, 1'b1);
    @(negedge clk);
    check("rd_dma_rvalid", dma_rvalid, 1'b1);
    check("rd_dma_rdata", dma_rdata, 32'h12345678);
    check("rd_core_rvalid", core_rvalid, 1'b0);
    @(negedge clk);
    check("rd_rvalid_pulse", dma_rvalid, 1'b0);
    check("rd_rdata_held", dma_rdata, 32'h12345678);
    check("rd_idle_after", busy, 1'b0);

    // Core read followed immediately by a core write
    xact(1'b0, 1'b1, 9'h020, 32'hAAAA5555, lat);
    @(negedge clk);
    t_req = cyc;
    xact(1'b0, 1'b0, 9'h020, '0, lat);
    xact(1'b0, 1'b1, 9'h021, 32'h0BADF00D, lat);
    check("rd_then_wr_mem_wr", mem_wr, 1'b1);
    check("rd_then_wr_spacing", (cyc - t_req) >= 3, 1'b1);

    // Reset during RESP of a core read, DMA request held through reset
    @(negedge clk);
    xact(1'b0, 1'b0, 9'h020, '0, lat);
    @(negedge clk);
    check("resp_rvalid_before_rst", core_rvalid, 1'b1);
    reset = 1'b0;
    fork
      xact(1'b1, 1'b1, 9'h1A0, 32'h5A5A5A5A, lat_d);
      begin
        @(negedge clk);
        check("rst_mid_strobes", {core_gnt, dma_gnt, core_rvalid, dma_rvalid, mem_wr, mem_rd, busy}, 7'd0);
        check("rst_mid_rdata", {core_rdata, dma_rdata}, 64'd0);
        check("rst_mid_mem", {mem_addr, mem_wdata}, 0);
        @(negedge clk);
        reset = 1'b1;
      end
    join
    check("dma_gnt_after_release", lat_d, 3);

    // Randomized mixed traffic from both requesters
    @(negedge clk);
    fork
      rand_driver(1'b0, 40);
      rand_driver(1'b1, 40);
    join
    repeat (5) @(negedge clk);
    check("core_cmd_q_drained", core_cmd_q.size(), 0);
    check("dma_cmd_q_drained", dma_cmd_q.size(), 0);
    check("core_rd_q_drained", core_rd_q.size(), 0);
    check("dma_rd_q_drained", dma_rd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width of every data port.
REQ-002 SHALL have parameter ADDR_W, default 9, data-memory word address width.
REQ-003 SHALL have parameter MAX_CONSEC, default 4, maximum number of consecutive core grants while a DMA request is pending; legal range 1..15.
REQ-004 SHALL run on one clock, with a synchronous, active-low reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous reset, active low.
REQ-007 SHALL have port core_req, input, 1 bit: core (datapath) access request.
REQ-008 SHALL have port core_we, input, 1 bit: core request is a write (1) or a read (0).
REQ-009 SHALL have port core_addr, input, ADDR_W bits: core word address.
REQ-010 SHALL have port core_wdata, input, DATA_W bits: core write data.
REQ-011 SHALL have port core_gnt, output, 1 bit: one-cycle pulse, core command issued to memory.
REQ-012 SHALL have port core_rvalid, output, 1 bit: one-cycle pulse, core_rdata valid.
REQ-013 SHALL have port core_rdata, output, DATA_W bits: core read data.
REQ-014 SHALL have the ports dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid and dma_rdata, identical in direction, width and meaning to the core_* ports, for the DMA/debug requester.
REQ-015 SHALL have port mem_wr, output, 1 bit: memory write strobe.
REQ-016 SHALL have port mem_rd, output, 1 bit: memory read strobe.
REQ-017 SHALL have port mem_addr, output, ADDR_W bits: memory address.
REQ-018 SHALL have port mem_wdata, output, DATA_W bits: memory write data.
REQ-019 SHALL have port mem_rdata, input, DATA_W bits: memory read data, valid the cycle after mem_rd.
REQ-020 SHALL have port busy, output, 1 bit: FSM not in IDLE.

Function
REQ-021 SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-022 SHALL, in IDLE when at least one request is high, latch the winner's id, we, addr and wdata into registers and go to ACCESS; with no request it SHALL stay in IDLE.
REQ-023 SHALL, in ACCESS, drive mem_wr=we or mem_rd=!we from the latched command, with mem_addr and mem_wdata taken from the latched registers, and pulse the winner's gnt for exactly one cycle.
REQ-024 SHALL, from ACCESS, go to RESP for a read and to IDLE for a write.
REQ-025 SHALL, in RESP, register mem_rdata into the winner's rdata, pulse the winner's rvalid for one cycle and return to IDLE.
REQ-026 SHALL give a write a request-to-grant latency of 1 cycle and an occupancy of 2 cycles.
REQ-027 SHALL give a read a request-to-grant latency of 1 cycle, grant-to-rvalid of 1 cycle and an occupancy of 3 cycles.
REQ-028 SHALL require each requester to hold req, we, addr and wdata stable until its gnt; req SHALL be deasserted, or a new request presented, in the cycle after gnt.
REQ-029 SHALL sample requests only in IDLE; requests arriving in ACCESS or RESP wait.
REQ-030 SHALL, when only one request is high, grant that requester.
REQ-031 SHALL, when both requests are high, grant the core unless consec_cnt == MAX_CONSEC, in which case the DMA wins.
REQ-032 SHALL keep a consec_cnt, 4 bits, that increments on a core win while dma_req is high, clears on any DMA win, is held on a core win with dma_req low, and saturates at MAX_CONSEC.
REQ-033 SHALL hold the non-winner's rdata, rvalid and gnt unchanged, at rdata held and 0 respectively.
REQ-034 SHALL drive mem_wr and mem_rd low outside ACCESS, and never high together.
REQ-035 SHALL drive busy high in ACCESS and RESP.

Reset
REQ-036 SHALL, with reset low at a clock edge, force state=IDLE, consec_cnt=0, all gnt, rvalid, mem_wr and mem_rd=0, and all rdata, mem_addr and mem_wdata=0.
REQ-037 SHALL, on reset mid-operation (ACCESS or RESP), abort the transaction: no gnt and no rvalid issued after reset, and arbitration resumes in the first cycle after reset is released.

Verification
REQ-038 SHALL be verified with: core write addr 0x010 data 0xDEADBEEF -> next cycle mem_wr=1, mem_addr=0x010, mem_wdata=0xDEADBEEF, core_gnt=1; IDLE one cycle later.
REQ-039 SHALL be verified with: DMA read addr 0x1FF, mem_rdata=0x12345678 the cycle after mem_rd -> dma_gnt at cycle+1, dma_rvalid=1 with dma_rdata=0x12345678 at cycle+2; core_rvalid stays 0.
REQ-040 SHALL be verified with: core and DMA requesting continuously (writes), MAX_CONSEC=4 -> grant order C,C,C,C,D repeating; DMA is never starved.
REQ-041 SHALL be verified with: both requesting simultaneously from IDLE after reset -> core granted first, with consec_cnt=1 afterwards.
REQ-042 SHALL be verified with: reset asserted in the RESP state of a core read -> no core_rvalid, and all outputs 0 the next cycle; a DMA request held through reset is granted 1 cycle after release.
REQ-043 SHALL be verified with: a core read followed immediately by a core write -> the write's mem_wr occurs at least 3 cycles after the read's core_req, and mem_rd and mem_wr are never high in the same cycle.
